// File: rtl/cmd_pkg.sv
// cmd_pkg: shared types and constants for the command frame decoder and register block.
package cmd_pkg;

    typedef enum logic [2:0] {
        S_MAGIC,
        S_COUNT,
        S_ADDR,
        S_DATA,
        S_DRAIN
    } state_t;

    localparam logic [7:0] CMD_MAGIC     = 8'hA5;
    localparam int         CMD_REC_BYTES = 5;

    localparam logic [7:0] CMD_SEND           = 8'd2;
    localparam logic [7:0] CMD_SRC_MAC_HI     = 8'd24;
    localparam logic [7:0] CMD_SRC_MAC_LO     = 8'd28;
    localparam logic [7:0] CMD_DST_MAC_HI     = 8'd32;
    localparam logic [7:0] CMD_DST_MAC_LO     = 8'd36;
    localparam logic [7:0] CMD_SRC_IP         = 8'd40;
    localparam logic [7:0] CMD_DST_IP         = 8'd44;
    localparam logic [7:0] CMD_SRC_PORT       = 8'd48;
    localparam logic [7:0] CMD_DST_PORT       = 8'd52;
    localparam logic [7:0] CMD_UDP_LEN        = 8'd60;
    localparam logic [7:0] CMD_ARP_OP         = 8'd64;
    localparam logic [7:0] CMD_ARP_DST_MAC_HI = 8'd68;
    localparam logic [7:0] CMD_ARP_DST_MAC_LO = 8'd72;
    localparam logic [7:0] CMD_ARP_DST_IP     = 8'd76;
    localparam logic [7:0] CMD_ARP_SRC_MAC_HI = 8'd80;
    localparam logic [7:0] CMD_ARP_SRC_MAC_LO = 8'd84;
    localparam logic [7:0] CMD_ARP_SRC_IP     = 8'd88;

endpackage

// File: rtl/cmd_frame_decoder.sv
// cmd_frame_decoder: parses MAGIC/N/records byte frames into single-cycle register writes
// and reports per-frame ok/error with a saturating error count.
module cmd_frame_decoder
    import cmd_pkg::*;
#(
    parameter logic [7:0] MAGIC = CMD_MAGIC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_vld,
    input  logic        i_rx_eop,
    output logic [7:0]  o_cmd_addr,
    output logic [31:0] o_cmd_data,
    output logic        o_cmd_wr,
    output logic        o_frame_ok,
    output logic        o_frame_err,
    output logic [15:0] o_err_cnt
);

    localparam logic [1:0] LAST_IDX = 2'(CMD_REC_BYTES - 2);

    state_t      state, state_nx;
    logic [7:0]  rem, addr_q;
    logic [1:0]  idx;
    logic [23:0] data_sh;
    logic        eop, last_byte, wr_nx, ok_nx, err_nx;

    assign eop       = i_rx_vld && i_rx_eop;
    assign last_byte = state == S_DATA && idx == LAST_IDX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_MAGIC;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (i_rx_vld) begin
            if (i_rx_eop)
                state_nx = S_MAGIC;
            else
                case (state)
                    S_MAGIC: state_nx = (i_rx_data == MAGIC) ? S_COUNT : S_DRAIN;
                    S_COUNT: state_nx = (i_rx_data == 8'd0) ? S_DRAIN : S_ADDR;
                    S_ADDR:  state_nx = S_DATA;
                    S_DATA:  state_nx = !last_byte ? S_DATA : (rem == 8'd1) ? S_DRAIN : S_ADDR;
                    default: state_nx = S_DRAIN;
                endcase
        end
    end

    // A frame is good only when eop lands exactly on its final expected byte.
    always_comb begin
        wr_nx  = i_rx_vld && last_byte;
        ok_nx  = eop && ((state == S_COUNT && i_rx_data == 8'd0) || (last_byte && rem == 8'd1));
        err_nx = eop && !ok_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cmd_addr  <= '0;
            o_cmd_data  <= '0;
            o_cmd_wr    <= 1'b0;
            o_frame_ok  <= 1'b0;
            o_frame_err <= 1'b0;
            o_err_cnt   <= '0;
            rem         <= '0;
            addr_q      <= '0;
            idx         <= '0;
            data_sh     <= '0;
        end else begin
            o_cmd_wr    <= wr_nx;
            o_frame_ok  <= ok_nx;
            o_frame_err <= err_nx;
            if (err_nx && o_err_cnt != 16'hFFFF)
                o_err_cnt <= o_err_cnt + 16'd1;
            if (wr_nx) begin
                o_cmd_addr <= addr_q;
                o_cmd_data <= {data_sh, i_rx_data};
            end
            if (i_rx_vld) begin
                if (state == S_COUNT)
                    rem <= i_rx_data;
                if (state == S_ADDR) begin
                    addr_q <= i_rx_data;
                    idx    <= '0;
                end
                if (state == S_DATA) begin
                    data_sh <= {data_sh[15:0], i_rx_data};
                    idx     <= idx + 2'd1;
                    if (last_byte)
                        rem <= rem - 8'd1;
                end
            end
        end
    end

endmodule
